bcp_engine: RTL and testbench

BCP_ENGINE -- requirements
Module: bcp_engine

---
 rtl/bcp_engine.sv | 162 ++++++++++++++++
 tb/tb_bcp_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcp_engine.sv
// Boolean constraint propagation engine: walks a clause range, looks up the
// var state of each 3-literal clause and pushes unit implications or flags a conflict.
module bcp_engine #(
    parameter int MAX_VARS_BITS    = 8,
    parameter int MAX_CLAUSES_BITS = 10
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [MAX_CLAUSES_BITS-1:0]   start_clause,
    input  logic [MAX_CLAUSES_BITS-1:0]   end_clause,
    output logic                          clause_rd_en,
    output logic [MAX_CLAUSES_BITS-1:0]   clause_addr,
    input  logic [3*(MAX_VARS_BITS+2)-1:0] clause_data,
    output logic                          vs_rd_en,
    output logic [MAX_VARS_BITS-1:0]      vs_var0,
    output logic [MAX_VARS_BITS-1:0]      vs_var1,
    output logic [MAX_VARS_BITS-1:0]      vs_var2,
    input  logic                          vs_assigned0,
    input  logic                          vs_assigned1,
    input  logic                          vs_assigned2,
    input  logic                          vs_val0,
    input  logic                          vs_val1,
    input  logic                          vs_val2,
    input  logic                          full_imply,
    output logic                          push_imply,
    output logic [MAX_VARS_BITS-1:0]      var_in_imply,
    output logic                          val_in_imply,
    output logic                          bcp_busy,
    output logic                          conflict,
    output logic [MAX_CLAUSES_BITS-1:0]   bcp_clause_idx
);

    // state  | meaning
    // IDLE   | waiting for start; conflict/bcp_clause_idx hold last result
    // FETCH  | clause memory read of clause idx
    // LOOKUP | clause word arrives; var-state read of its three variables
    // EVAL   | classify literals; next clause, conflict, or push (stalls on full_imply)
    localparam int LW = MAX_VARS_BITS + 2;

    typedef enum logic [1:0] {IDLE, FETCH, LOOKUP, EVAL} state_t;

    state_t                      state_q;
    logic [MAX_CLAUSES_BITS-1:0] idx_q;
    logic [MAX_CLAUSES_BITS-1:0] end_q;
    logic [3*LW-1:0]             clause_q;
    logic                        hold_q;
    logic [2:0]                  asg_q;
    logic [2:0]                  val_q;
    logic                        conflict_q;
    logic                        push_q;
    logic [MAX_VARS_BITS-1:0]    imp_var_q;
    logic                        imp_val_q;

    logic [2:0]                  asg_d;
    logic [2:0]                  val_d;
    logic [2:0]                  lit_true;
    logic [1:0]                  n_free;
    logic [MAX_VARS_BITS-1:0]    free_var;
    logic                        free_neg;
    logic                        eval_conf;
    logic                        eval_unit;

    // Var-state answers are only valid on the first EVAL cycle; a stall replays the captured copy.
    always_comb begin
        asg_d    = hold_q ? asg_q : {vs_assigned2, vs_assigned1, vs_assigned0};
        val_d    = hold_q ? val_q : {vs_val2, vs_val1, vs_val0};
        lit_true = '0;
        n_free   = '0;
        free_var = '0;
        free_neg = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (clause_q[i*LW + LW-1]) begin
                if (asg_d[i]) begin
                    lit_true[i] = (val_d[i] != clause_q[i*LW + LW-2]);
                end else begin
                    n_free   = n_free + 2'd1;
                    free_var = clause_q[i*LW +: MAX_VARS_BITS];
                    free_neg = clause_q[i*LW + LW-2];
                end
            end
        end
        eval_conf = ~(|lit_true) & (n_free == 2'd0);
        eval_unit = ~(|lit_true) & (n_free == 2'd1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            end_q      <= '0;
            clause_q   <= '0;
            hold_q     <= 1'b0;
            asg_q      <= '0;
            val_q      <= '0;
            conflict_q <= 1'b0;
            push_q     <= 1'b0;
            imp_var_q  <= '0;
            imp_val_q  <= 1'b0;
        end else begin
            push_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        end_q      <= end_clause;
                        idx_q      <= start_clause;
                        conflict_q <= 1'b0;
                        if (start_clause <= end_clause) begin
                            state_q <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    state_q <= LOOKUP;
                end
                LOOKUP: begin
                    clause_q <= clause_data;
                    hold_q   <= 1'b0;
                    state_q  <= EVAL;
                end
                EVAL: begin
                    asg_q <= asg_d;
                    val_q <= val_d;
                    if (eval_conf) begin
                        conflict_q <= 1'b1;
                        state_q    <= IDLE;
                    end else if (eval_unit && full_imply) begin
                        hold_q <= 1'b1;
                    end else begin
                        if (eval_unit) begin
                            push_q    <= 1'b1;
                            imp_var_q <= free_var;
                            imp_val_q <= ~free_neg;
                        end
                        // Stopping on idx == end keeps idx from wrapping at the top clause.
                        if (idx_q == end_q) begin
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= FETCH;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bcp_busy       = (state_q != IDLE);
    assign clause_rd_en   = (state_q == FETCH);
    assign clause_addr    = idx_q;
    assign vs_rd_en       = (state_q == LOOKUP);
    assign vs_var0        = (state_q == LOOKUP) ? clause_data[0 +: MAX_VARS_BITS]    : clause_q[0 +: MAX_VARS_BITS];
    assign vs_var1        = (state_q == LOOKUP) ? clause_data[LW +: MAX_VARS_BITS]   : clause_q[LW +: MAX_VARS_BITS];
    assign vs_var2        = (state_q == LOOKUP) ? clause_data[2*LW +: MAX_VARS_BITS] : clause_q[2*LW +: MAX_VARS_BITS];
    assign push_imply     = push_q;
    assign var_in_imply   = imp_var_q;
    assign val_in_imply   = imp_val_q;
    assign conflict       = conflict_q;
    assign bcp_clause_idx = idx_q;

endmodule

// File: tb/tb_bcp_engine.sv
// Directed bench for bcp_engine with behavioural clause memory and var-state models.
module tb_bcp_engine;

    localparam int VB = 8;
    localparam int CB = 10;
    localparam int LW = VB + 2;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [CB-1:0]   start_clause;
    logic [CB-1:0]   end_clause;
    logic            clause_rd_en;
    logic [CB-1:0]   clause_addr;
    logic [3*LW-1:0] clause_data;
    logic            vs_rd_en;
    logic [VB-1:0]   vs_var0, vs_var1, vs_var2;
    logic            vs_assigned0, vs_assigned1, vs_assigned2;
    logic            vs_val0, vs_val1, vs_val2;
    logic            full_imply;
    logic            push_imply;
    logic [VB-1:0]   var_in_imply;
    logic            val_in_imply;
    logic            bcp_busy;
    logic            conflict;
    logic [CB-1:0]   bcp_clause_idx;

    int checks = 0;
    int fails  = 0;
    int busy_cnt, push_cnt, fetch_cnt;
    int last_fetch, push_var, push_val;

    logic [3*LW-1:0] cmem   [0:1023];
    logic            vs_asg [0:255];
    logic            vs_v   [0:255];

    bcp_engine #(.MAX_VARS_BITS(VB), .MAX_CLAUSES_BITS(CB)) dut (
        .clock(clock), .reset(reset), .start(start),
        .start_clause(start_clause), .end_clause(end_clause),
        .clause_rd_en(clause_rd_en), .clause_addr(clause_addr), .clause_data(clause_data),
        .vs_rd_en(vs_rd_en), .vs_var0(vs_var0), .vs_var1(vs_var1), .vs_var2(vs_var2),
        .vs_assigned0(vs_assigned0), .vs_assigned1(vs_assigned1), .vs_assigned2(vs_assigned2),
        .vs_val0(vs_val0), .vs_val1(vs_val1), .vs_val2(vs_val2),
        .full_imply(full_imply), .push_imply(push_imply),
        .var_in_imply(var_in_imply), .val_in_imply(val_in_imply),
        .bcp_busy(bcp_busy), .conflict(conflict), .bcp_clause_idx(bcp_clause_idx)
    );

    always #5 clock = ~clock;

    // Memories answer one cycle after the strobe and drive zeros otherwise,
    // so stale or mistimed sampling shows up as wrong results.
    always @(posedge clock) begin
        clause_data <= clause_rd_en ? cmem[clause_addr] : '0;
        if (vs_rd_en) begin
            vs_assigned0 <= vs_asg[vs_var0]; vs_val0 <= vs_v[vs_var0];
            vs_assigned1 <= vs_asg[vs_var1]; vs_val1 <= vs_v[vs_var1];
            vs_assigned2 <= vs_asg[vs_var2]; vs_val2 <= vs_v[vs_var2];
        end else begin
            vs_assigned0 <= 1'b0; vs_val0 <= 1'b0;
            vs_assigned1 <= 1'b0; vs_val1 <= 1'b0;
            vs_assigned2 <= 1'b0; vs_val2 <= 1'b0;
        end
    end

    always @(negedge clock) begin
        if (bcp_busy) busy_cnt++;
        if (push_imply) begin
            push_cnt++;
            push_var = int'(var_in_imply);
            push_val = int'(val_in_imply);
        end
        if (clause_rd_en) begin
            fetch_cnt++;
            last_fetch = int'(clause_addr);
        end
    end

    function automatic logic [LW-1:0] lit(input logic v, input logic n, input logic [VB-1:0] x);
        return {v, n, x};
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        busy_cnt = 0; push_cnt = 0; fetch_cnt = 0;
        last_fetch = -1; push_var = -1; push_val = -1;
    endtask

    task automatic start_pass(input int s, input int e);
        @(negedge clock);
        start = 1'b1;
        start_clause = CB'(s);
        end_clause = CB'(e);
        clear_mon();
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bcp_busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(tag, int'(bcp_busy), 0);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; full_imply = 1'b0;
        start_clause = '0; end_clause = '0;
        for (int i = 0; i < 1024; i++) cmem[i] = '0;
        for (int i = 0; i < 256; i++) begin vs_asg[i] = 1'b0; vs_v[i] = 1'b0; end
        clear_mon();

        vs_asg[10] = 1; vs_v[10] = 1;
        vs_asg[11] = 1; vs_v[11] = 0;
        vs_asg[13] = 1; vs_v[13] = 1;
        vs_asg[3]  = 1; vs_v[3]  = 0;
        vs_asg[1]  = 1; vs_v[1]  = 0;
        vs_asg[2]  = 1; vs_v[2]  = 0;
        vs_asg[21] = 1; vs_v[21] = 1;

        cmem[0]    = {lit(0,0,0), lit(0,0,0), lit(1,0,10)};
        cmem[1]    = {lit(0,0,0), lit(1,1,11), lit(0,0,0)};
        cmem[2]    = {lit(0,0,0), lit(1,0,13), lit(1,0,12)};
        cmem[3]    = {lit(0,0,0), lit(0,0,0), lit(1,0,30)};
        cmem[4]    = {lit(0,0,7), lit(1,1,5), lit(1,0,3)};
        cmem[5]    = {lit(0,0,0), lit(0,0,0), lit(1,0,10)};
        cmem[6]    = {lit(0,0,0), lit(1,0,2), lit(1,0,1)};
        cmem[7]    = {lit(0,0,0), lit(0,0,0), lit(1,0,50)};
        cmem[8]    = {lit(0,0,0), lit(1,1,21), lit(1,0,20)};
        cmem[9]    = {lit(0,0,0), lit(0,0,0), lit(1,0,10)};
        cmem[11]   = {lit(0,0,0), lit(1,0,3), lit(1,0,40)};
        cmem[12]   = {lit(0,0,0), lit(0,0,0), lit(1,0,40)};
        cmem[1023] = {lit(0,0,0), lit(0,0,0), lit(1,0,10)};

        repeat (3) @(negedge clock);
        check("rst_busy", int'(bcp_busy), 0);
        check("rst_conflict", int'(conflict), 0);
        check("rst_push", int'(push_imply), 0);
        check("rst_rd_en", int'(clause_rd_en), 0);
        check("rst_vs_rd_en", int'(vs_rd_en), 0);
        check("rst_idx", int'(bcp_clause_idx), 0);
        check("rst_var", int'(var_in_imply), 0);
        check("rst_val", int'(val_in_imply), 0);
        reset = 1'b0;

        // all-satisfied range 0..2
        start_pass(0, 2);
        check("sat_busy_next_cycle", int'(bcp_busy), 1);
        wait_idle("sat_timeout");
        check("sat_busy_cycles", busy_cnt, 9);
        check("sat_push", push_cnt, 0);
        check("sat_conflict", int'(conflict), 0);
        check("sat_fetches", fetch_cnt, 3);
        check("sat_last_fetch", last_fetch, 2);

        // unit clause 4 implies x5 = 0
        start_pass(4, 4);
        wait_idle("unit_timeout");
        check("unit_push_cnt", push_cnt, 1);
        check("unit_var", push_var, 5);
        check("unit_val", push_val, 0);
        check("unit_conflict", int'(conflict), 0);
        check("unit_busy_cycles", busy_cnt, 3);

        // conflict at clause 6 in range 5..9
        start_pass(5, 9);
        wait_idle("conf_timeout");
        check("conf_flag", int'(conflict), 1);
        check("conf_idx", int'(bcp_clause_idx), 6);
        check("conf_fetches", fetch_cnt, 2);
        check("conf_last_fetch", last_fetch, 6);
        check("conf_busy_cycles", busy_cnt, 6);
        check("conf_push", push_cnt, 0);
        repeat (4) @(negedge clock);
        check("conf_hold_flag", int'(conflict), 1);
        check("conf_hold_idx", int'(bcp_clause_idx), 6);

        // reversed range: never busy, clears the old conflict
        start_pass(10, 0);
        check("rev_busy", int'(bcp_busy), 0);
        check("rev_conflict", int'(conflict), 0);
        repeat (3) @(negedge clock);
        check("rev_fetches", fetch_cnt, 0);
        check("rev_busy_cycles", busy_cnt, 0);

        // conflict again, then reset and start together: reset wins
        start_pass(5, 9);
        wait_idle("conf2_timeout");
        check("conf2_flag", int'(conflict), 1);
        @(negedge clock);
        reset = 1'b1; start = 1'b1; start_clause = 10'd0; end_clause = 10'd2;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        check("rst_start_busy", int'(bcp_busy), 0);
        check("rst_start_conflict", int'(conflict), 0);
        check("rst_start_idx", int'(bcp_clause_idx), 0);

        // full_imply stalls clause 8 for 4 EVAL cycles
        full_imply = 1'b1;
        start_pass(8, 9);
        repeat (6) @(negedge clock);
        check("stall_no_push_yet", push_cnt, 0);
        check("stall_busy", int'(bcp_busy), 1);
        full_imply = 1'b0;
        wait_idle("stall_timeout");
        check("stall_push_cnt", push_cnt, 1);
        check("stall_var", push_var, 20);
        check("stall_val", push_val, 1);
        check("stall_busy_cycles", busy_cnt, 10);
        check("stall_fetches", fetch_cnt, 2);

        // duplicate implications of x40; a mid-pass start is ignored
        start_pass(11, 12);
        @(negedge clock);
        start = 1'b1; start_clause = 10'd0; end_clause = 10'd0;
        @(negedge clock);
        start = 1'b0;
        wait_idle("dup_timeout");
        check("dup_push_cnt", push_cnt, 2);
        check("dup_var", push_var, 40);
        check("dup_val", push_val, 1);
        check("dup_fetches", fetch_cnt, 2);
        check("dup_last_fetch", last_fetch, 12);

        // top clause index terminates without wrapping
        start_pass(1023, 1023);
        wait_idle("top_timeout");
        check("top_fetches", fetch_cnt, 1);
        check("top_busy_cycles", busy_cnt, 3);
        check("top_idx", int'(bcp_clause_idx), 1023);
        check("top_conflict", int'(conflict), 0);

        // reset during LOOKUP of unit clause 3 aborts the push
        start_pass(3, 3);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", int'(bcp_busy), 0);
        check("abort_conflict", int'(conflict), 0);
        check("abort_push", int'(push_imply), 0);
        check("abort_var", int'(var_in_imply), 0);
        repeat (4) @(negedge clock);
        check("abort_no_push", push_cnt, 0);
        start_pass(3, 3);
        wait_idle("restart_timeout");
        check("restart_push_cnt", push_cnt, 1);
        check("restart_var", push_var, 30);
        check("restart_val", push_val, 1);
        check("restart_busy_cycles", busy_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
